// File: rtl/hand_sequencer_if.sv
// Card/state types and the pulse, card-handshake and display bundle between
// hand_sequencer (master) and its environment (slave).
package hand_sequencer_pkg;
  typedef logic [5:0] card_t;
  typedef enum logic [2:0] {
    PREFLOP  = 3'd0,
    FLOP     = 3'd1,
    TURN     = 3'd2,
    RIVER    = 3'd3,
    SHOWDOWN = 3'd4
  } hand_state_t;
endpackage

interface hand_sequencer_if;
  logic start_pulse;
  logic act_pulse;
  logic fold_pulse;
  logic next_pulse;
  logic card_req;
  logic card_valid;
  hand_sequencer_pkg::card_t card_in;
  logic winner_valid;
  logic winner_in;
  // [player][slot]
  hand_sequencer_pkg::card_t [1:0][1:0] player_cards;
  hand_sequencer_pkg::card_t [2:0] flop_card;
  hand_sequencer_pkg::card_t turn_card;
  hand_sequencer_pkg::card_t river_card;
  hand_sequencer_pkg::hand_state_t curr_state;
  logic current_player;
  logic current_dealer;
  logic winner;
  logic start_state;
  logic game_state;
  logic wait_state;

  modport master (
    input  start_pulse, act_pulse, fold_pulse, next_pulse,
    input  card_valid, card_in, winner_valid, winner_in,
    output card_req, player_cards, flop_card, turn_card, river_card,
    output curr_state, current_player, current_dealer, winner,
    output start_state, game_state, wait_state
  );

  modport slave (
    output start_pulse, act_pulse, fold_pulse, next_pulse,
    output card_valid, card_in, winner_valid, winner_in,
    input  card_req, player_cards, flop_card, turn_card, river_card,
    input  curr_state, current_player, current_dealer, winner,
    input  start_state, game_state, wait_state
  );
endinterface

// File: rtl/hand_sequencer.sv
// Heads-up hold'em hand sequencer: start screen -> deal -> betting streets -> showdown -> wait.
// All outputs registered; one card accepted per cycle while card_req is high, none beyond the last needed.
module hand_sequencer
  import hand_sequencer_pkg::*;
#(
  parameter int ACTS_PER_ROUND  = 2,
  parameter int WAIT_MIN_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  hand_sequencer_if.master bus
);
  localparam int ACT_W  = $clog2(ACTS_PER_ROUND + 1);
  localparam int WAIT_W = $clog2(WAIT_MIN_CYCLES + 1);
  localparam logic [ACT_W-1:0]  ACT_LAST = ACT_W'(ACTS_PER_ROUND - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WAIT_MIN_CYCLES);

  typedef enum logic [2:0] {
    S_START, S_DEAL_HOLE, S_BET, S_DEAL_BOARD, S_SHOW, S_WAIT
  } fsm_t;

  fsm_t                 state_q;
  logic                 card_req_q;
  logic [1:0]           card_idx_q;
  card_t [1:0][1:0]     hole_q;
  card_t [2:0]          flop_q;
  card_t                turn_q;
  card_t                river_q;
  hand_state_t          street_q;
  logic                 player_q;
  logic                 dealer_q;
  logic                 winner_q;
  logic                 start_q;
  logic                 game_q;
  logic                 wait_q;
  logic [ACT_W-1:0]     act_cnt_q;
  logic [WAIT_W-1:0]    wait_cnt_q;

  logic take;
  logic board_last;
  logic new_hand;

  assign take       = card_req_q & bus.card_valid;
  // Flop needs three cards, turn and river one each.
  assign board_last = (street_q != PREFLOP) || (card_idx_q == 2'd2);
  assign new_hand   = ((state_q == S_START) && bus.start_pulse) ||
                      ((state_q == S_WAIT) && bus.next_pulse && (wait_cnt_q == WAIT_SAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_START;
      card_req_q <= 1'b0;
      card_idx_q <= '0;
      hole_q     <= '0;
      flop_q     <= '0;
      turn_q     <= '0;
      river_q    <= '0;
      street_q   <= PREFLOP;
      player_q   <= 1'b0;
      dealer_q   <= 1'b0;
      winner_q   <= 1'b0;
      start_q    <= 1'b1;
      game_q     <= 1'b0;
      wait_q     <= 1'b0;
      act_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else if (new_hand) begin
      state_q    <= S_DEAL_HOLE;
      card_req_q <= 1'b1;
      card_idx_q <= '0;
      hole_q     <= '0;
      flop_q     <= '0;
      turn_q     <= '0;
      river_q    <= '0;
      street_q   <= PREFLOP;
      start_q    <= 1'b0;
      game_q     <= 1'b1;
      wait_q     <= 1'b0;
      act_cnt_q  <= '0;
      wait_cnt_q <= '0;
      if (state_q == S_WAIT) dealer_q <= ~dealer_q;
    end else begin
      case (state_q)
        S_DEAL_HOLE: begin
          // Non-dealer receives first: card k goes to player (dealer ^ ~k[0]), slot k[1].
          if (take) begin
            hole_q[dealer_q ^ ~card_idx_q[0]][card_idx_q[1]] <= bus.card_in;
            card_idx_q <= card_idx_q + 2'd1;
            if (card_idx_q == 2'd3) begin
              state_q    <= S_BET;
              card_req_q <= 1'b0;
              player_q   <= dealer_q;
            end
          end
        end
        S_BET: begin
          if (bus.fold_pulse) begin
            winner_q  <= ~player_q;
            state_q   <= S_WAIT;
            game_q    <= 1'b0;
            wait_q    <= 1'b1;
            act_cnt_q <= '0;
          end else if (bus.act_pulse) begin
            player_q <= ~player_q;
            if (act_cnt_q == ACT_LAST) begin
              act_cnt_q <= '0;
              if (street_q == RIVER) begin
                state_q  <= S_SHOW;
                street_q <= SHOWDOWN;
              end else begin
                state_q    <= S_DEAL_BOARD;
                card_req_q <= 1'b1;
                card_idx_q <= '0;
              end
            end else begin
              act_cnt_q <= act_cnt_q + ACT_W'(1);
            end
          end
        end
        S_DEAL_BOARD: begin
          if (take) begin
            card_idx_q <= card_idx_q + 2'd1;
            case (street_q)
              PREFLOP: flop_q[card_idx_q] <= bus.card_in;
              FLOP:    turn_q  <= bus.card_in;
              TURN:    river_q <= bus.card_in;
              default: ;
            endcase
            if (board_last) begin
              state_q    <= S_BET;
              card_req_q <= 1'b0;
              card_idx_q <= '0;
              player_q   <= ~dealer_q;
              case (street_q)
                PREFLOP: street_q <= FLOP;
                FLOP:    street_q <= TURN;
                default: street_q <= RIVER;
              endcase
            end
          end
        end
        S_SHOW: begin
          if (bus.winner_valid) begin
            winner_q <= bus.winner_in;
            state_q  <= S_WAIT;
            game_q   <= 1'b0;
            wait_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q != WAIT_SAT) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.card_req       = card_req_q;
  assign bus.player_cards   = hole_q;
  assign bus.flop_card      = flop_q;
  assign bus.turn_card      = turn_q;
  assign bus.river_card     = river_q;
  assign bus.curr_state     = street_q;
  assign bus.current_player = player_q;
  assign bus.current_dealer = dealer_q;
  assign bus.winner         = winner_q;
  assign bus.start_state    = start_q;
  assign bus.game_state     = game_q;
  assign bus.wait_state     = wait_q;

endmodule

// File: tb/tb_hand_sequencer.sv
// Bench for hand_sequencer: a hand-level model (list of dealt cards, phase, seat bits)
// checked against the DUT every cycle, plus directed literal checks.
module tb_hand_sequencer;
  import hand_sequencer_pkg::*;

  localparam int ACTS = 2;
  localparam int WMIN = 8;
  localparam logic [3:0] P_START = 4'b1000;
  localparam logic [3:0] P_ACT   = 4'b0100;
  localparam logic [3:0] P_FOLD  = 4'b0010;
  localparam logic [3:0] P_NEXT  = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hand_sequencer_if bus();

  hand_sequencer #(
    .ACTS_PER_ROUND (ACTS),
    .WAIT_MIN_CYCLES(WMIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- hand-level model ----------------
  typedef enum {M_START, M_HOLE, M_BET, M_BOARD, M_SHOW, M_WAIT} mph_t;
  mph_t  m_ph;
  card_t m_deal[$];
  int    m_acts;
  int    m_wait;
  bit    m_player, m_dealer, m_winner, m_show;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = M_START; m_deal.delete(); m_acts = 0; m_wait = 0;
      m_player = 0; m_dealer = 0; m_winner = 0; m_show = 0;
    end else begin
      case (m_ph)
        M_START: if (bus.start_pulse) begin
          m_ph = M_HOLE; m_deal.delete(); m_show = 0;
        end
        M_HOLE: if (bus.card_valid) begin
          m_deal.push_back(bus.card_in);
          if (m_deal.size() == 4) begin m_ph = M_BET; m_player = m_dealer; end
        end
        M_BET: if (bus.fold_pulse) begin
          m_winner = !m_player; m_ph = M_WAIT; m_wait = 0; m_acts = 0;
        end else if (bus.act_pulse) begin
          m_acts++; m_player = !m_player;
          if (m_acts == ACTS) begin
            m_acts = 0;
            if (m_deal.size() == 9) begin m_ph = M_SHOW; m_show = 1; end
            else m_ph = M_BOARD;
          end
        end
        M_BOARD: if (bus.card_valid) begin
          m_deal.push_back(bus.card_in);
          if (m_deal.size() inside {7, 8, 9}) begin m_ph = M_BET; m_player = !m_dealer; end
        end
        M_SHOW: if (bus.winner_valid) begin
          m_winner = bus.winner_in; m_ph = M_WAIT; m_wait = 0;
        end
        M_WAIT: if (bus.next_pulse && m_wait >= WMIN) begin
          m_dealer = !m_dealer; m_ph = M_HOLE; m_deal.delete(); m_show = 0;
        end else m_wait++;
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  card_t [1:0][1:0] e_hole;
  card_t [2:0]      e_flop;
  card_t            e_turn, e_river;
  hand_state_t      e_street;
  logic [2:0]       e_screen;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_hole = '0; e_flop = '0; e_turn = '0; e_river = '0;
      for (int k = 0; k < m_deal.size(); k++) begin
        if (k < 4) e_hole[(k % 2 == 0) ? !m_dealer : m_dealer][k / 2] = m_deal[k];
        else if (k < 7) e_flop[k - 4] = m_deal[k];
        else if (k == 7) e_turn = m_deal[k];
        else e_river = m_deal[k];
      end
      e_street = m_show ? SHOWDOWN : (m_deal.size() >= 9) ? RIVER :
                 (m_deal.size() >= 8) ? TURN : (m_deal.size() >= 7) ? FLOP : PREFLOP;
      e_screen = {m_ph == M_START, !(m_ph inside {M_START, M_WAIT}), m_ph == M_WAIT};
      chk("cyc_card_req", bus.card_req, m_ph inside {M_HOLE, M_BOARD});
      chk("cyc_hole", bus.player_cards, e_hole);
      chk("cyc_flop", bus.flop_card, e_flop);
      chk("cyc_turn", bus.turn_card, e_turn);
      chk("cyc_river", bus.river_card, e_river);
      chk("cyc_street", bus.curr_state, e_street);
      chk("cyc_player", bus.current_player, m_player);
      chk("cyc_dealer", bus.current_dealer, m_dealer);
      chk("cyc_winner", bus.winner, m_winner);
      chk("cyc_screens", {bus.start_state, bus.game_state, bus.wait_state}, e_screen);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {bus.start_pulse, bus.act_pulse, bus.fold_pulse, bus.next_pulse} = m;
    @(negedge clk);
    {bus.start_pulse, bus.act_pulse, bus.fold_pulse, bus.next_pulse} = 4'b0000;
  endtask

  task automatic feed(input card_t c);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.card_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("feed_timeout_card_req", bus.card_req, 1'b1);
    bus.card_valid = 1'b1;
    bus.card_in    = c;
    @(negedge clk);
    bus.card_valid = 1'b0;
    bus.card_in    = '0;
  endtask

  task automatic stray_card(input card_t c);
    @(negedge clk);
    bus.card_valid = 1'b1;
    bus.card_in    = c;
    @(negedge clk);
    bus.card_valid = 1'b0;
    bus.card_in    = '0;
  endtask

  // Entered at the negedge of the first WAIT cycle; cycle c sees counter c-1.
  task automatic wait_then_next(input logic exp_dealer);
    for (int c = 1; c <= WMIN + 4; c++) begin
      bus.next_pulse = (c == 3) || (c == WMIN + 1);
      @(negedge clk);
      if (c == 3) chk("wait_early_next_ignored", bus.wait_state, 1'b1);
      if (c == WMIN + 1) begin
        chk("wait_next_game_state", bus.game_state, 1'b1);
        chk("wait_next_dealer", bus.current_dealer, exp_dealer);
        chk("wait_next_card_req", bus.card_req, 1'b1);
        break;
      end
    end
    bus.next_pulse = 1'b0;
  endtask

  initial begin
    {bus.start_pulse, bus.act_pulse, bus.fold_pulse, bus.next_pulse} = 4'b0000;
    bus.card_valid = 1'b0; bus.card_in = '0;
    bus.winner_valid = 1'b0; bus.winner_in = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_screens", {bus.start_state, bus.game_state, bus.wait_state}, 3'b100);
    chk("rst_card_req", bus.card_req, 1'b0);
    chk("rst_street", bus.curr_state, PREFLOP);
    chk("rst_seats", {bus.current_player, bus.current_dealer, bus.winner}, 3'b000);
    reset = 1'b0;

    // Pulses and cards outside their owning state do nothing.
    pulse(P_ACT | P_FOLD);
    pulse(P_NEXT);
    stray_card(6'd63);
    chk("start_ignores_stray", {bus.start_state, bus.card_req}, 2'b10);

    // Hand 1, dealer 0.
    pulse(P_START);
    chk("start_game_req", {bus.game_state, bus.card_req}, 2'b11);
    feed(6'd10); feed(6'd11); feed(6'd12); feed(6'd13);
    chk("hole_p1", bus.player_cards[1], {6'd12, 6'd10});
    chk("hole_p0", bus.player_cards[0], {6'd13, 6'd11});
    chk("hole_player", bus.current_player, 1'b0);
    chk("hole_req_off", bus.card_req, 1'b0);
    stray_card(6'd62);
    @(negedge clk);
    bus.winner_valid = 1'b1; bus.winner_in = 1'b1;
    @(negedge clk);
    bus.winner_valid = 1'b0; bus.winner_in = 1'b0;
    chk("bet_ignores_winner_valid", bus.winner, 1'b0);
    pulse(P_ACT);
    pulse(P_ACT);
    chk("flop_req_on", bus.card_req, 1'b1);
    pulse(P_FOLD);
    chk("deal_ignores_fold", bus.wait_state, 1'b0);
    feed(6'd20);
    chk("flop_x_street", bus.curr_state, PREFLOP);
    feed(6'd21);
    chk("flop_y_street", bus.curr_state, PREFLOP);
    feed(6'd22);
    chk("flop_cards", bus.flop_card, {6'd22, 6'd21, 6'd20});
    chk("flop_z_street", bus.curr_state, FLOP);
    chk("flop_player", bus.current_player, 1'b1);
    pulse(P_ACT | P_FOLD);
    chk("fold_winner", bus.winner, 1'b0);
    chk("fold_wait", {bus.start_state, bus.game_state, bus.wait_state}, 3'b001);
    chk("fold_act_ignored", bus.current_player, 1'b1);
    wait_then_next(1'b1);

    // Hand 2, dealer 1, played to showdown.
    pulse(P_ACT);
    feed(6'd30); feed(6'd31); feed(6'd32); feed(6'd33);
    chk("hand2_p0", bus.player_cards[0], {6'd32, 6'd30});
    chk("hand2_p1", bus.player_cards[1], {6'd33, 6'd31});
    chk("hand2_player", bus.current_player, 1'b1);
    pulse(P_ACT); pulse(P_ACT);
    feed(6'd34); feed(6'd35); feed(6'd36);
    chk("hand2_flop_player", bus.current_player, 1'b0);
    pulse(P_ACT); pulse(P_ACT);
    feed(6'd37);
    chk("hand2_turn", {bus.curr_state, bus.turn_card}, {FLOP == TURN ? 3'd0 : TURN, 6'd37});
    pulse(P_ACT); pulse(P_ACT);
    feed(6'd38);
    chk("hand2_river", {bus.curr_state, bus.river_card}, {RIVER, 6'd38});
    pulse(P_ACT); pulse(P_ACT);
    chk("show_street", bus.curr_state, SHOWDOWN);
    chk("show_screens", {bus.start_state, bus.game_state, bus.wait_state, bus.card_req}, 4'b0100);
    @(negedge clk);
    bus.winner_valid = 1'b1; bus.winner_in = 1'b1;
    @(negedge clk);
    bus.winner_valid = 1'b0; bus.winner_in = 1'b0;
    chk("show_winner", bus.winner, 1'b1);
    chk("show_to_wait", {bus.wait_state, bus.curr_state}, {1'b1, SHOWDOWN});
    wait_then_next(1'b0);

    // Hand 3: reset lands mid-flop while a card is still wanted.
    feed(6'd40); feed(6'd41); feed(6'd42); feed(6'd43);
    pulse(P_ACT); pulse(P_ACT);
    feed(6'd44); feed(6'd45);
    chk("midflop_req", bus.card_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_card_req", bus.card_req, 1'b0);
    chk("arst_screens", {bus.start_state, bus.game_state, bus.wait_state}, 3'b100);
    chk("arst_cards", {bus.player_cards, bus.flop_card}, '0);
    chk("arst_street", bus.curr_state, PREFLOP);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
